debouncer_mc: RTL and testbench
===============================

DEBOUNCER_MC -- requirements
Module: debouncer_mc

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of independent input channels (>=1).
REQ-002 Parameter FACTOR_POW, default 6, SHALL set the integrator counter width (>=2); saturation value is 2^FACTOR_POW-1.
REQ-003 Parameter PRESC_POW, default 0, SHALL set the shared prescaler width; 0 SHALL mean the integrator updates every clock.
REQ-004 Parameter INIT_LEVEL, default 0, SHALL set the 1-bit reset level of every channel.
REQ-005 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007 in  input  CHANNELS  SHALL carry raw, asynchronous, bouncing inputs, one bit per channel.
REQ-008 out  output  CHANNELS  SHALL carry the registered debounced level per channel.
REQ-009 rise_o  output  CHANNELS  SHALL pulse high one cycle per channel on each debounced 0->1 transition.
REQ-010 fall_o  output  CHANNELS  SHALL pulse high one cycle per channel on each debounced 1->0 transition.
REQ-011 changed_o  output  1  SHALL be the OR of all rise_o and fall_o bits.

Function
REQ-012 Each channel SHALL pass in through a two-flop synchronizer (sync1, sync2); only sync2 SHALL feed the integrator.
REQ-013 One prescaler shared by all channels SHALL count freely; tick SHALL be high in the cycle it equals all-ones; PRESC_POW=0 SHALL make tick constantly 1.
REQ-014 On tick, a channel counter SHALL increment if sync2=1 and counter != max, decrement if sync2=0 and counter != 0, else hold; without tick it SHALL hold.
REQ-015 Counter arithmetic SHALL saturate and never wrap at 0 or at max.
REQ-016 out SHALL be set on the edge where the counter's next value equals max, cleared on the edge where next value equals 0, and hold otherwise (full hysteresis; intermediate values do not change out).
REQ-017 rise_o/fall_o SHALL assert on the same edge out changes, for exactly one cycle, and SHALL never both be high on one channel.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-019 Latency (PRESC_POW=0): a level held from before edge 1 SHALL reach sync2 at edge 2; the counter SHALL move from edge 3; out SHALL change at edge 2+(2^FACTOR_POW-1) for a full swing.
REQ-020 A glitch shorter than the distance to the opposite rail SHALL only move the counter and SHALL NOT change out.
REQ-021 With PRESC_POW>0, full-swing latency SHALL be 2^FACTOR_POW-1 ticks, ticks occurring every 2^PRESC_POW clocks.

Reset
REQ-022 While rst_i=1, sync1, sync2 and out SHALL be INIT_LEVEL on all channels; counters SHALL be max if INIT_LEVEL=1, else 0; prescaler SHALL be 0.
REQ-023 While rst_i=1, rise_o, fall_o and changed_o SHALL be 0; deassertion SHALL NOT produce a pulse.
REQ-024 Reset asserted mid-integration SHALL immediately (asynchronously) discard counter progress and return all state to REQ-022 values.

Verification
REQ-025 Defaults, in=4'b0001 held from reset release -> out[0] rises at edge 65, rise_o[0]=1 that cycle only, changed_o=1, other channels stay 0.
REQ-026 Defaults, channel 0 at out=1, in[0]=0 for 10 cycles then 1 -> counter dips to 53 and recovers to 63, out[0] stays 1, no fall_o pulse.
REQ-027 Defaults, in=4'b1111 at once -> all four out bits and rise_o bits assert on the same edge (65).
REQ-028 PRESC_POW=2, FACTOR_POW=3, in[0]=1 -> out[0] rises after 7 ticks (~28 clocks after sync), counter changes only on tick cycles.
REQ-029 INIT_LEVEL=1, in=0 -> out starts 1 with no pulse at reset release, falls after 63 updates with one fall_o pulse.
REQ-030 Defaults, rst_i pulsed mid-count (counter=40) -> out, counter, pulses return to 0 without waiting for a clock edge; count restarts from 0.

Source files
------------

// File: rtl/debouncer_mc.sv
// Multi-channel input debouncer: 2-flop synchronizer plus saturating integrator per channel,
// with full hysteresis on the output and one-cycle rise/fall pulses.

module debouncer_mc_lane #(
    parameter int   FACTOR_POW = 6,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [FACTOR_POW-1:0] MAX     = '1;
    localparam logic [FACTOR_POW-1:0] RST_CNT = {FACTOR_POW{INIT_LEVEL}};

    logic                  sync1, sync2;
    logic [FACTOR_POW-1:0] cnt, cnt_nxt;

    // Saturating integrator: only moves on prescaler ticks, never wraps.
    always_comb begin
        cnt_nxt = cnt;
        if (tick) begin
            if (sync2 && cnt != MAX)
                cnt_nxt = cnt + 1'b1;
            else if (!sync2 && cnt != '0)
                cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= INIT_LEVEL;
            sync2 <= INIT_LEVEL;
            cnt   <= RST_CNT;
            level <= INIT_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Output only flips when the integrator reaches a rail.
            if (cnt_nxt == MAX && !level) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end else if (cnt_nxt == '0 && level) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end
        end
    end
endmodule

module debouncer_mc #(
    parameter int   CHANNELS   = 4,
    parameter int   FACTOR_POW = 6,
    parameter int   PRESC_POW  = 0,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                changed_o
);
    logic tick;

    generate
        if (PRESC_POW == 0) begin : g_nopresc
            assign tick = 1'b1;
        end else begin : g_presc
            logic [PRESC_POW-1:0] presc;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) presc <= '0;
                else       presc <= presc + 1'b1;
            end
            assign tick = &presc;
        end
    endgenerate

    debouncer_mc_lane #(
        .FACTOR_POW (FACTOR_POW),
        .INIT_LEVEL (INIT_LEVEL)
    ) u_lane [CHANNELS-1:0] (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick  (tick),
        .raw   (in),
        .level (out),
        .rise  (rise_o),
        .fall  (fall_o)
    );

    assign changed_o = |(rise_o | fall_o);
endmodule

// File: tb/tb_debouncer_mc.sv
// Bench for debouncer_mc: three configurations (defaults, prescaled, INIT_LEVEL=1) run
// side by side and are compared every cycle against a behavioural integrator model.

module tb_debouncer_mc;
    localparam int ND = 3;
    localparam int FP [ND] = '{6, 3, 6};
    localparam int PP [ND] = '{0, 2, 0};
    localparam int IL [ND] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ND-1:0][3:0] din;

    logic [3:0] o0, o1, o2, r0, r1, r2, f0, f1, f2;
    logic       c0, c1, c2;
    logic [3:0] dout [ND];
    logic [3:0] drise[ND];
    logic [3:0] dfall[ND];
    logic       dchg [ND];

    assign dout[0] = o0;  assign dout[1] = o1;  assign dout[2] = o2;
    assign drise[0] = r0; assign drise[1] = r1; assign drise[2] = r2;
    assign dfall[0] = f0; assign dfall[1] = f1; assign dfall[2] = f2;
    assign dchg[0] = c0;  assign dchg[1] = c1;  assign dchg[2] = c2;

    always #5 clk = ~clk;

    debouncer_mc #(.CHANNELS(4), .FACTOR_POW(6), .PRESC_POW(0), .INIT_LEVEL(1'b0)) u0 (
        .clk_i(clk), .rst_i(rst), .in(din[0]), .out(o0), .rise_o(r0), .fall_o(f0), .changed_o(c0));
    debouncer_mc #(.CHANNELS(4), .FACTOR_POW(3), .PRESC_POW(2), .INIT_LEVEL(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .in(din[1]), .out(o1), .rise_o(r1), .fall_o(f1), .changed_o(c1));
    debouncer_mc #(.CHANNELS(4), .FACTOR_POW(6), .PRESC_POW(0), .INIT_LEVEL(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .in(din[2]), .out(o2), .rise_o(r2), .fall_o(f2), .changed_o(c2));

    // ---------------- reference model ----------------
    logic [3:0] m_s1  [ND];
    logic [3:0] m_s2  [ND];
    logic [3:0] m_out [ND];
    logic [3:0] m_rise[ND];
    logic [3:0] m_fall[ND];
    int         m_lvl [ND][4];
    int         m_presc[ND];

    function automatic int max_of(int d);
        return (1 << FP[d]) - 1;
    endfunction

    function automatic logic tick_of(int d, int presc);
        return (PP[d] == 0) || (presc == (1 << PP[d]) - 1);
    endfunction

    function automatic int nxt_lvl(int lvl, logic s, logic tk, int mx);
        if (!tk) return lvl;
        if (s)   return (lvl < mx) ? lvl + 1 : mx;
        return (lvl > 0) ? lvl - 1 : 0;
    endfunction

    function automatic logic nxt_out(int nl, int mx, logic o);
        if (nl == mx) return 1'b1;
        if (nl == 0)  return 1'b0;
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_s1[d]    <= (IL[d] != 0) ? 4'hF : 4'h0;
                m_s2[d]    <= (IL[d] != 0) ? 4'hF : 4'h0;
                m_out[d]   <= (IL[d] != 0) ? 4'hF : 4'h0;
                m_rise[d]  <= 4'h0;
                m_fall[d]  <= 4'h0;
                m_presc[d] <= 0;
                for (int c = 0; c < 4; c++)
                    m_lvl[d][c] <= (IL[d] != 0) ? max_of(d) : 0;
            end else begin
                m_s1[d]    <= din[d];
                m_s2[d]    <= m_s1[d];
                m_presc[d] <= (PP[d] == 0) ? 0 : (m_presc[d] + 1) % (1 << PP[d]);
                for (int c = 0; c < 4; c++) begin
                    m_lvl[d][c]  <= nxt_lvl(m_lvl[d][c], m_s2[d][c], tick_of(d, m_presc[d]), max_of(d));
                    m_out[d][c]  <= nxt_out(nxt_lvl(m_lvl[d][c], m_s2[d][c], tick_of(d, m_presc[d]), max_of(d)),
                                            max_of(d), m_out[d][c]);
                    m_rise[d][c] <= nxt_out(nxt_lvl(m_lvl[d][c], m_s2[d][c], tick_of(d, m_presc[d]), max_of(d)),
                                            max_of(d), m_out[d][c]) & ~m_out[d][c];
                    m_fall[d][c] <= ~nxt_out(nxt_lvl(m_lvl[d][c], m_s2[d][c], tick_of(d, m_presc[d]), max_of(d)),
                                             max_of(d), m_out[d][c]) & m_out[d][c];
                end
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_out%0d", tag, d),  dout[d],  m_out[d]);
            chk($sformatf("%s_rise%0d", tag, d), drise[d], m_rise[d]);
            chk($sformatf("%s_fall%0d", tag, d), dfall[d], m_fall[d]);
            chk($sformatf("%s_chg%0d", tag, d),  {3'b0, dchg[d]}, {3'b0, |(m_rise[d] | m_fall[d])});
        end
    endtask

    task automatic step(string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) step("rst");
        rst = 1'b0;
    endtask

    initial begin
        din = '0;
        din[2] = 4'h0;

        // reset values
        repeat (3) step("rst");
        chk("rst_out_u0", dout[0], 4'h0);
        chk("rst_out_u2", dout[2], 4'hF);
        chk("rst_pulse_u2", drise[2] | dfall[2], 4'h0);

        // u0 ch0 rises at edge 65, u1 ch0 after 7 ticks (edge 28), u2 falls at edge 65
        din[0] = 4'b0001;
        din[1] = 4'b0001;
        din[2] = 4'b0000;
        rst = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            step("swing");
            if (e == 1) begin
                chk("rel_out_u2", dout[2], 4'hF);
                chk("rel_nopulse_u2", drise[2] | dfall[2], 4'h0);
            end
            if (e == 27) chk("presc_e27", dout[1], 4'h0);
            if (e == 28) chk("presc_e28", dout[1], 4'h1);
            if (e == 64) begin
                chk("u0_e64", dout[0], 4'h0);
                chk("u2_e64", dout[2], 4'hF);
            end
            if (e == 65) begin
                chk("u0_e65_out", dout[0], 4'h1);
                chk("u0_e65_rise", drise[0], 4'h1);
                chk("u0_e65_chg", {3'b0, dchg[0]}, 4'h1);
                chk("u2_e65_out", dout[2], 4'h0);
                chk("u2_e65_fall", dfall[2], 4'hF);
            end
            if (e == 66) chk("u0_e66_rise", drise[0], 4'h0);
        end

        // short glitch on a saturated channel must not reach the output
        din[0][0] = 1'b0;
        repeat (10) begin
            step("glitch");
            chk("glitch_hold", dout[0], 4'h1);
        end
        din[0][0] = 1'b1;
        repeat (20) begin
            step("recover");
            chk("glitch_nofall", dfall[0], 4'h0);
        end

        // reset mid-integration acts without a clock edge
        reset_pulse();
        din[0] = 4'b0001;
        repeat (42) step("mid");
        #2 rst = 1'b1;
        #1;
        chk("async_out", dout[0], 4'h0);
        chk("async_pulse", drise[0] | dfall[0], 4'h0);
        chk("async_u2", dout[2], 4'hF);
        step("async");
        step("async");
        rst = 1'b0;
        for (int e = 1; e <= 66; e++) begin
            step("restart");
            if (e == 64) chk("restart_e64", dout[0], 4'h0);
            if (e == 65) chk("restart_e65", drise[0], 4'h1);
        end

        // all channels together
        reset_pulse();
        din[0] = 4'b1111;
        for (int e = 1; e <= 66; e++) begin
            step("all");
            if (e == 65) begin
                chk("all_out", dout[0], 4'hF);
                chk("all_rise", drise[0], 4'hF);
            end
        end

        // random: fast chatter, then slow level changes
        repeat (400) begin
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(0, 3) == 0) din[d][c] = ~din[d][c];
            step("rnd_fast");
        end
        repeat (3000) begin
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(0, 79) == 0) din[d][c] = ~din[d][c];
            step("rnd_slow");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
